// File: rtl/queue_cntrl_mc.sv
// queue_cntrl_mc: address/occupancy controller for C FIFOs of N entries sharing one RAM.
// Define QUEUE_CNTRL_MC_ERR_EN to build the sticky overflow/underflow flags.
module queue_cntrl_mc #(
    parameter int C = 4,
    parameter int N = 6,
    parameter int AFULL = N - 1,
    parameter int CH_W = (C > 1) ? $clog2(C) : 1,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1,
    parameter int CNT_W = $clog2(N + 1),
    parameter int ADDR_W = (C * N > 1) ? $clog2(C * N) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_push,
    input  logic [CH_W-1:0]      i_push_ch,
    input  logic                 i_pop,
    input  logic [CH_W-1:0]      i_pop_ch,
    output logic                 o_wen,
    output logic [ADDR_W-1:0]    o_wa,
    output logic                 o_ren,
    output logic [ADDR_W-1:0]    o_ra,
    output logic [C-1:0]         o_full,
    output logic [C-1:0]         o_empty,
    output logic [C-1:0]         o_afull,
    output logic [C*CNT_W-1:0]   o_count,
    output logic                 o_err_ovf,
    output logic                 o_err_udf
);
    logic [PTR_W-1:0] wptr_q [C];
    logic [PTR_W-1:0] wptr_d [C];
    logic [PTR_W-1:0] rptr_q [C];
    logic [PTR_W-1:0] rptr_d [C];
    logic [CNT_W-1:0] cnt_q [C];
    logic [CNT_W-1:0] cnt_d [C];
    logic [C-1:0] full_q, full_d, empty_q, empty_d, afull_q, afull_d;
    logic [C-1:0] push_hit, pop_hit;
    logic [PTR_W-1:0] wsel, rsel;
    logic wfull, rempty;

    function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(N - 1)) ? '0 : p + 1'b1;
    endfunction

    // Channel numbers with no matching channel leave wfull/rempty set, rejecting the request.
    always_comb begin
        wsel = '0;
        rsel = '0;
        wfull = 1'b1;
        rempty = 1'b1;
        for (int c = 0; c < C; c++) begin
            if (i_push_ch == CH_W'(c)) begin
                wsel = wptr_q[c];
                wfull = full_q[c];
            end
            if (i_pop_ch == CH_W'(c)) begin
                rsel = rptr_q[c];
                rempty = empty_q[c];
            end
        end
    end

    assign o_wen = i_push & ~wfull;
    assign o_ren = i_pop & ~rempty;
    assign o_wa = ADDR_W'(i_push_ch) * ADDR_W'(N) + ADDR_W'(wsel);
    assign o_ra = ADDR_W'(i_pop_ch) * ADDR_W'(N) + ADDR_W'(rsel);

    always_comb begin
        push_hit = '0;
        pop_hit = '0;
        full_d = '0;
        empty_d = '0;
        afull_d = '0;
        for (int c = 0; c < C; c++) begin
            push_hit[c] = o_wen && (i_push_ch == CH_W'(c));
            pop_hit[c] = o_ren && (i_pop_ch == CH_W'(c));
            wptr_d[c] = push_hit[c] ? inc(wptr_q[c]) : wptr_q[c];
            rptr_d[c] = pop_hit[c] ? inc(rptr_q[c]) : rptr_q[c];
            cnt_d[c] = (push_hit[c] && !pop_hit[c]) ? cnt_q[c] + 1'b1 :
                       (pop_hit[c] && !push_hit[c]) ? cnt_q[c] - 1'b1 : cnt_q[c];
            full_d[c] = cnt_d[c] == CNT_W'(N);
            empty_d[c] = cnt_d[c] == '0;
            afull_d[c] = cnt_d[c] >= CNT_W'(AFULL);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '{default: '0};
            rptr_q <= '{default: '0};
            cnt_q <= '{default: '0};
            full_q <= '0;
            empty_q <= '1;
            afull_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q <= cnt_d;
            full_q <= full_d;
            empty_q <= empty_d;
            afull_q <= afull_d;
        end
    end

    always_comb begin
        o_count = '0;
        for (int c = 0; c < C; c++) o_count[c*CNT_W +: CNT_W] = cnt_q[c];
    end

    assign o_full = full_q;
    assign o_empty = empty_q;
    assign o_afull = afull_q;

`ifdef QUEUE_CNTRL_MC_ERR_EN
    logic err_ovf_q, err_ovf_d, err_udf_q, err_udf_d;

    always_comb begin
        err_ovf_d = err_ovf_q | (i_push & ~o_wen);
        err_udf_d = err_udf_q | (i_pop & ~o_ren);
    end

    always_ff @(posedge clk) begin
        err_ovf_q <= rst ? 1'b0 : err_ovf_d;
        err_udf_q <= rst ? 1'b0 : err_udf_d;
    end

    assign o_err_ovf = err_ovf_q;
    assign o_err_udf = err_udf_q;
`else
    assign o_err_ovf = 1'b0;
    assign o_err_udf = 1'b0;
`endif
endmodule

// File: tb/tb_queue_cntrl_mc.sv
// tb_queue_cntrl_mc: scenario and random checks of queue_cntrl_mc (C=4, N=6) against
// a per-channel push/pop tally model.
module tb_queue_cntrl_mc;
    localparam int C = 4;
    localparam int N = 6;
`ifdef QUEUE_CNTRL_MC_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif
    localparam logic [23:0] RST_STATUS = 24'h0F0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_push = 1'b0, i_pop = 1'b0;
    logic [1:0] i_push_ch = '0, i_pop_ch = '0;
    logic o_wen, o_ren, o_err_ovf, o_err_udf;
    logic [4:0] o_wa, o_ra;
    logic [3:0] o_full, o_empty, o_afull;
    logic [11:0] o_count;

    queue_cntrl_mc dut (
        .clk(clk), .rst(rst), .i_push(i_push), .i_push_ch(i_push_ch),
        .i_pop(i_pop), .i_pop_ch(i_pop_ch), .o_wen(o_wen), .o_wa(o_wa),
        .o_ren(o_ren), .o_ra(o_ra), .o_full(o_full), .o_empty(o_empty),
        .o_afull(o_afull), .o_count(o_count), .o_err_ovf(o_err_ovf), .o_err_udf(o_err_udf)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int pushed [C];
    int popped [C];
    bit m_ovf, m_udf;
    bit a_r, a_p, a_q;
    int a_pc, a_qc;
    bit e_wen, e_ren;
    logic [4:0] e_wa, e_ra;

    function automatic logic [23:0] status();
        logic [3:0] fu, em, af;
        logic [11:0] cv;
        for (int c = 0; c < C; c++) begin
            int n = pushed[c] - popped[c];
            cv[c*3 +: 3] = 3'(n);
            fu[c] = n == N;
            em[c] = n == 0;
            af[c] = n >= N - 1;
        end
        return {af, em, fu, cv};
    endfunction

    task automatic apply(input bit r, input bit p, input int pc, input bit q, input int qc);
        @(negedge clk);
        rst = r; i_push = p; i_push_ch = pc[1:0]; i_pop = q; i_pop_ch = qc[1:0];
        #1;
        a_r = r; a_p = p; a_pc = pc; a_q = q; a_qc = qc;
        e_wen = p && (pushed[pc] - popped[pc]) < N;
        e_ren = q && (pushed[qc] - popped[qc]) > 0;
        e_wa = 5'(pc * N + pushed[pc] % N);
        e_ra = 5'(qc * N + popped[qc] % N);
    endtask

    task automatic commit();
        @(posedge clk);
        if (a_r) begin
            for (int c = 0; c < C; c++) begin pushed[c] = 0; popped[c] = 0; end
            m_ovf = 0; m_udf = 0;
        end else begin
            if (e_wen) pushed[a_pc]++;
            if (e_ren) popped[a_qc]++;
            if (a_p && !e_wen && ERR) m_ovf = 1;
            if (a_q && !e_ren && ERR) m_udf = 1;
        end
        #1;
    endtask

    task automatic test_reset();
        apply(1, 0, 0, 0, 0);
        commit();
        checks++;
        if ({o_afull, o_empty, o_full, o_count} !== RST_STATUS) begin
            failures++;
            $display("FAIL reset_status got=%h exp=%h", {o_afull, o_empty, o_full, o_count}, RST_STATUS);
        end
        checks++;
        if ({o_err_ovf, o_err_udf} !== 2'b00) begin
            failures++;
            $display("FAIL reset_err got=%b exp=00", {o_err_ovf, o_err_udf});
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < N; i++) begin
            apply(0, 1, 2, 0, 0);
            checks++;
            if (o_wen !== 1'b1 || o_wa !== 5'(12 + i)) begin
                failures++;
                $display("FAIL fill_wa[%0d] got wen=%b wa=%0d exp wen=1 wa=%0d", i, o_wen, o_wa, 12 + i);
            end
            commit();
            checks++;
            if (o_afull[2] !== (i >= 4) || o_full[2] !== (i == 5) || {o_afull, o_empty, o_full, o_count} !== status()) begin
                failures++;
                $display("FAIL fill_status[%0d] got=%h exp=%h", i, {o_afull, o_empty, o_full, o_count}, status());
            end
        end
        checks++;
        if (o_count[8:6] !== 3'd6) begin
            failures++;
            $display("FAIL fill_count got=%0d exp=6", o_count[8:6]);
        end
    endtask

    task automatic test_full_push_pop();
        apply(0, 1, 2, 1, 2);
        checks++;
        if (o_wen !== 1'b0 || o_ren !== 1'b1 || o_ra !== 5'd12) begin
            failures++;
            $display("FAIL full_pp got wen=%b ren=%b ra=%0d exp wen=0 ren=1 ra=12", o_wen, o_ren, o_ra);
        end
        commit();
        checks++;
        if (o_count[8:6] !== 3'd5 || o_err_ovf !== ERR) begin
            failures++;
            $display("FAIL full_pp_after got cnt=%0d ovf=%b exp cnt=5 ovf=%b", o_count[8:6], o_err_ovf, ERR);
        end
    endtask

    task automatic test_wrap();
        apply(0, 1, 0, 0, 0);
        commit();
        for (int i = 0; i < 10; i++) begin
            apply(0, 1, 0, 1, 0);
            checks++;
            if (o_wen !== 1'b1 || o_ren !== 1'b1 || o_wa !== 5'((i + 1) % 6) || o_ra !== 5'(i % 6) || o_wa >= 5'd6) begin
                failures++;
                $display("FAIL wrap[%0d] got wen=%b ren=%b wa=%0d ra=%0d exp wa=%0d ra=%0d",
                         i, o_wen, o_ren, o_wa, o_ra, (i + 1) % 6, i % 6);
            end
            commit();
            checks++;
            if (o_count[2:0] !== 3'd1) begin
                failures++;
                $display("FAIL wrap_count[%0d] got=%0d exp=1", i, o_count[2:0]);
            end
        end
    endtask

    task automatic test_empty_push_pop();
        apply(0, 1, 1, 1, 1);
        checks++;
        if (o_wen !== 1'b1 || o_ren !== 1'b0) begin
            failures++;
            $display("FAIL empty_pp got wen=%b ren=%b exp wen=1 ren=0", o_wen, o_ren);
        end
        commit();
        checks++;
        if (o_count[5:3] !== 3'd1 || o_err_udf !== ERR) begin
            failures++;
            $display("FAIL empty_pp_after got cnt=%0d udf=%b exp cnt=1 udf=%b", o_count[5:3], o_err_udf, ERR);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin apply(0, 1, 0, 0, 0); commit(); end
        checks++;
        if (o_count[2:0] !== 3'd4) begin
            failures++;
            $display("FAIL b2b_start got=%0d exp=4", o_count[2:0]);
        end
        for (int i = 0; i < 4; i++) begin
            apply(0, 1, 3, 1, 0);
            checks++;
            if (o_wen !== 1'b1 || o_ren !== 1'b1 || o_wa !== 5'(18 + i) || o_ra !== e_ra) begin
                failures++;
                $display("FAIL b2b[%0d] got wen=%b ren=%b wa=%0d ra=%0d exp wa=%0d ra=%0d",
                         i, o_wen, o_ren, o_wa, o_ra, 18 + i, e_ra);
            end
            commit();
        end
        checks++;
        if (o_count[11:9] !== 3'd4 || o_count[2:0] !== 3'd0 || o_empty[0] !== 1'b1) begin
            failures++;
            $display("FAIL b2b_end got c3=%0d c0=%0d empty0=%b exp c3=4 c0=0 empty0=1",
                     o_count[11:9], o_count[2:0], o_empty[0]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            int bias = (i / 100) % 2 == 0 ? 3 : 1;
            apply(0, $urandom_range(0, 3) < bias, $urandom_range(0, 3), $urandom_range(0, 3) >= bias, $urandom_range(0, 3));
            checks++;
            if (o_wen !== e_wen || o_ren !== e_ren || (e_wen && o_wa !== e_wa) || (e_ren && o_ra !== e_ra)) begin
                failures++;
                $display("FAIL rand_addr[%0d] got wen=%b wa=%0d ren=%b ra=%0d exp wen=%b wa=%0d ren=%b ra=%0d",
                         i, o_wen, o_wa, o_ren, o_ra, e_wen, e_wa, e_ren, e_ra);
            end
            commit();
            checks++;
            if ({o_afull, o_empty, o_full, o_count} !== status() || o_err_ovf !== m_ovf || o_err_udf !== m_udf) begin
                failures++;
                $display("FAIL rand_status[%0d] got=%h err=%b%b exp=%h err=%b%b", i,
                         {o_afull, o_empty, o_full, o_count}, o_err_ovf, o_err_udf, status(), m_ovf, m_udf);
            end
        end
    endtask

    task automatic test_mid_reset();
        apply(1, 0, 0, 0, 0);
        commit();
        for (int i = 0; i < 3; i++) begin apply(0, 1, 0, 0, 0); commit(); end
        checks++;
        if (o_count[2:0] !== 3'd3) begin
            failures++;
            $display("FAIL midrst_pre got=%0d exp=3", o_count[2:0]);
        end
        apply(1, 1, 0, 1, 1);
        commit();
        checks++;
        if ({o_afull, o_empty, o_full, o_count} !== RST_STATUS || {o_err_ovf, o_err_udf} !== 2'b00) begin
            failures++;
            $display("FAIL midrst_status got=%h err=%b%b exp=%h err=00",
                     {o_afull, o_empty, o_full, o_count}, o_err_ovf, o_err_udf, RST_STATUS);
        end
        apply(0, 1, 0, 0, 0);
        checks++;
        if (o_wen !== 1'b1 || o_wa !== 5'd0) begin
            failures++;
            $display("FAIL midrst_wa got wen=%b wa=%0d exp wen=1 wa=0", o_wen, o_wa);
        end
        commit();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_push_pop();
        test_wrap();
        test_empty_push_pop();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/queue_cntrl_mc.md
# queue_cntrl_mc

Multi-channel queue controller generating write/read addresses for C independent FIFOs packed into one shared single-port-write, single-port-read synchronous RAM. Each channel holds N entries, where N is any integer ≥ 2, not just a power of two. The block tracks per-channel pointers and occupancy, and reports full, empty, almost-full and occupancy count. It sits between producer/consumer arbitration logic and the shared storage array.

## Interface
- `C`, default 4: number of channels (≥1).
- `N`, default 6: entries per channel (≥2, any integer).
- `AFULL`, default N-1: almost-full threshold; `o_afull[c]` asserts when count[c] ≥ AFULL (1 ≤ AFULL ≤ N).
- `CH_W`, default max(1,$clog2(C)): channel-select width.
- `PTR_W`, default max(1,$clog2(N)): per-channel pointer width.
- `CNT_W`, default $clog2(N+1): occupancy width.
- `ADDR_W`, default max(1,$clog2(C*N)): RAM address width.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `i_push`  in  1  push request.
- `i_push_ch`  in  CH_W  push target channel.
- `i_pop`  in  1  pop request.
- `i_pop_ch`  in  CH_W  pop target channel.
- `o_wen`  out  1  RAM write enable; also the push accept.
- `o_wa`  out  ADDR_W  RAM write address.
- `o_ren`  out  1  RAM read enable; also the pop accept.
- `o_ra`  out  ADDR_W  RAM read address.
- `o_full`  out  C  per-channel full, registered.
- `o_empty`  out  C  per-channel empty, registered.
- `o_afull`  out  C  per-channel almost-full, registered.
- `o_count`  out  C*CNT_W  per-channel occupancy, registered; channel c at bits [c*CNT_W +: CNT_W].
- `o_err_ovf`  out  1  sticky overflow (see Configuration).
- `o_err_udf`  out  1  sticky underflow (see Configuration).

## Operation
- Per-channel state: `wptr[c]`, `rptr[c]` (PTR_W bits) and `cnt[c]` (CNT_W bits).
- Pointer increment: wraps from N-1 to 0 by compare, not by modulo-2^k. The non-power-of-two wrap must be exact.
- Address: `o_wa` = i_push_ch*N + wptr[i_push_ch]; `o_ra` = i_pop_ch*N + rptr[i_pop_ch]. Arithmetic is zero-extended to ADDR_W.
- Push accept: `o_wen` = i_push & ~full[i_push_ch]. A push to a full channel is dropped, even when a same-channel pop is accepted in the same cycle, because read and write would address the same entry.
- Pop accept: `o_ren` = i_pop & ~empty[i_pop_ch]. A pop to an empty channel is dropped, even with a same-channel push the same cycle; there is no bypass.
- Counter update per channel c:
  - +1 on accepted push only.
  - −1 on accepted pop only.
  - Unchanged when both or neither are accepted.
- Status: full = (cnt==N), empty = (cnt==0), afull = (cnt ≥ AFULL). All are derived from registered cnt.
- Out-of-range channel (i_push_ch or i_pop_ch ≥ C): treated as full (push) or empty (pop), so the request is rejected and raises the corresponding error.
- Reset values:
  - All pointers 0, all counts 0.
  - `o_empty` all-ones, `o_full`/`o_afull` all-zero (`o_afull` all-ones only if AFULL==0, which is disallowed).
  - Errors 0.
- Reset mid-operation: all channel state discarded at the next edge; RAM contents are not cleared.

## Timing
- `o_wen`/`o_wa`/`o_ren`/`o_ra` are combinational from requests and registered state, with zero latency.
- RAM read data is valid the cycle after `o_ren`. That path belongs to the consumer.
- Status outputs reflect accepted operations one cycle after acceptance.
- Push and pop to different channels in the same cycle are fully independent.
- Throughput: one push and one pop per cycle, sustained, in any channel combination.

## Configuration
- `QUEUE_CNTRL_MC_ERR_EN` defined:
  - `o_err_ovf` sets on any rejected push.
  - `o_err_udf` sets on any rejected pop.
  - Both are sticky until `rst`.
- Macro undefined: both error outputs are tied 0 and the error flops are not instantiated. All other behaviour is identical.

## Test plan
- Reset, then fill ch2 with 6 pushes (N=6, C=4):
  - `o_wa` = 12,13,14,15,16,17.
  - `o_full[2]`=1 after the 6th push.
  - `o_afull[2]`=1 after the 5th push.
  - `o_count` ch2 = 6.
- With ch2 full, push ch2 and pop ch2 together: `o_wen`=0, `o_ren`=1, `o_ra`=12, count→5, `o_err_ovf`=1 (with ERR_EN).
- Wrap-around: run 10 push/pop pairs on ch0 at steady occupancy 1. Addresses cycle 0..5 then 0; `o_wa` never reaches 6.
- Empty ch1, push ch1 and pop ch1 together: `o_ren`=0, `o_wen`=1, count[1]→1, `o_err_udf`=1.
- Push ch3 and pop ch0 concurrently for 4 cycles from ch0 count=4: ch3 count→4, ch0 count→0, `o_empty[0]`=1.
- Assert `rst` mid-traffic with ch0 count=3: the next cycle shows all counts 0, `o_empty`=4'b1111, and the next push ch0 gives `o_wa`=0.
